// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared video timing defaults (640x480@60) and a helper that derives the
// total period of one axis (active + front porch + sync + back porch).
// No ports; imported by video_timing and framebuffer_scanout.
// -----------------------------------------------------------------------------
package video_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Negative-going sync pulses by default.
  localparam bit SYNC_ACTIVE_DEF = 1'b0;

  function automatic int span_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing.sv
// -----------------------------------------------------------------------------
// video_timing
// Free-running raster counters with sync generation and position strobes.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high; counters return to (0,0)
//   visible      current position is inside the active picture
//   visible_next position of the next clock is inside the active picture
//   line_active  current line is one of the visible lines
//   line_end     last clock of a line (hCount = H_TOTAL-1)
//   frame_end    last clock of a frame (line_end on the last line)
//   frame_start  current position is (0,0)
//   h_sync       horizontal sync at SYNC_ACTIVE level inside the pulse
//   v_sync       vertical sync at SYNC_ACTIVE level inside the pulse
// -----------------------------------------------------------------------------
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter bit SYNC_ACTIVE = SYNC_ACTIVE_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic visible,
  output logic visible_next,
  output logic line_active,
  output logic line_end,
  output logic frame_end,
  output logic frame_start,
  output logic h_sync,
  output logic v_sync
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_count, h_next;
  logic [VW-1:0] v_count, v_next;

  assign line_end     = (h_count == HW'(H_TOTAL - 1));
  assign frame_end    = line_end && (v_count == VW'(V_TOTAL - 1));
  assign line_active  = (v_count < VW'(V_ACTIVE));
  assign visible      = (h_count < HW'(H_ACTIVE)) && line_active;
  assign visible_next = (h_next < HW'(H_ACTIVE)) && (v_next < VW'(V_ACTIVE));
  assign frame_start  = (h_count == '0) && (v_count == '0);

  assign h_sync = ((h_count >= HW'(H_ACTIVE + H_FP)) &&
                   (h_count <  HW'(H_ACTIVE + H_FP + H_SYNC))) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign v_sync = ((v_count >= VW'(V_ACTIVE + V_FP)) &&
                   (v_count <  VW'(V_ACTIVE + V_FP + V_SYNC))) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    h_next = h_count + HW'(1);
    v_next = v_count;
    if (line_end) begin
      h_next = '0;
      v_next = frame_end ? '0 : v_count + VW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else begin
      h_count <= h_next;
      v_count <= v_next;
    end
  end

endmodule

// File: rtl/framebuffer_scanout.sv
// -----------------------------------------------------------------------------
// framebuffer_scanout
// Display-side read stage of a double-buffered framebuffer. Walks the raster,
// issues read addresses with SCALE x SCALE pixel replication and realigns the
// timing signals to the framebuffer's one-cycle registered read.
//
// Ports:
//   clk           pixel clock (same as framebuffer read clock)
//   reset         synchronous, active-high
//   fbAddress     read address to the framebuffer
//   fbData        framebuffer read data, valid one cycle after fbAddress
//   bufferSelect  buffer requested for the next frame
//   activeBuffer  buffer currently being scanned
//   hSync, vSync  sync outputs, aligned with pixelOut
//   dataEnable    pixelOut carries a visible pixel
//   pixelOut      pixel data, forced to 0 outside the active picture
//   frameStart    one-cycle pulse on the first visible pixel of a frame
// -----------------------------------------------------------------------------
module framebuffer_scanout
  import video_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int SCALE       = 2,
  parameter int FB_W        = 320,
  parameter int FB_H        = 240,
  parameter int PIXEL_WIDTH = 9,
  parameter int ADDR_WIDTH  = 18,
  parameter bit SYNC_ACTIVE = SYNC_ACTIVE_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  fbAddress,
  input  logic [PIXEL_WIDTH-1:0] fbData,
  input  logic                   bufferSelect,
  output logic                   activeBuffer,
  output logic                   hSync,
  output logic                   vSync,
  output logic                   dataEnable,
  output logic [PIXEL_WIDTH-1:0] pixelOut,
  output logic                   frameStart
);

  localparam int REP_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  // pixelIndex briefly reaches FB_W after the last visible pixel of a line.
  localparam int PIX_W = $clog2(FB_W + 1);

  localparam logic [REP_W-1:0]      REP_LAST  = REP_W'(SCALE - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(FB_W);
  localparam logic [ADDR_WIDTH-1:0] BUF1_BASE = ADDR_WIDTH'(FB_W * FB_H);

  logic visible, visible_next, line_active, line_end, frame_end, frame_start;
  logic h_sync_raw, v_sync_raw;

  video_timing #(
    .H_ACTIVE    (H_ACTIVE),
    .H_FP        (H_FP),
    .H_SYNC      (H_SYNC),
    .H_BP        (H_BP),
    .V_ACTIVE    (V_ACTIVE),
    .V_FP        (V_FP),
    .V_SYNC      (V_SYNC),
    .V_BP        (V_BP),
    .SYNC_ACTIVE (SYNC_ACTIVE)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .visible      (visible),
    .visible_next (visible_next),
    .line_active  (line_active),
    .line_end     (line_end),
    .frame_end    (frame_end),
    .frame_start  (frame_start),
    .h_sync       (h_sync_raw),
    .v_sync       (v_sync_raw)
  );

  // Address walker state always describes the current raster position.
  logic [REP_W-1:0]      h_rep, h_rep_n;
  logic [REP_W-1:0]      v_rep, v_rep_n;
  logic [PIX_W-1:0]      pixel_index, pixel_index_n;
  logic [ADDR_WIDTH-1:0] line_base, line_base_n;
  logic                  buffer_n;

  always_comb begin
    h_rep_n       = h_rep;
    v_rep_n       = v_rep;
    pixel_index_n = pixel_index;
    line_base_n   = line_base;
    buffer_n      = activeBuffer;

    if (visible) begin
      if (h_rep == REP_LAST) begin
        h_rep_n       = '0;
        pixel_index_n = pixel_index + PIX_W'(1);
      end else begin
        h_rep_n = h_rep + REP_W'(1);
      end
    end

    if (line_end) begin
      h_rep_n       = '0;
      pixel_index_n = '0;
      if (frame_end) begin
        // The only point where a new buffer is accepted, so a frame is
        // always read from a single buffer.
        v_rep_n     = '0;
        buffer_n    = bufferSelect;
        line_base_n = bufferSelect ? BUF1_BASE : '0;
      end else if (line_active) begin
        if (v_rep == REP_LAST) begin
          v_rep_n     = '0;
          line_base_n = line_base + LINE_STEP;
        end else begin
          v_rep_n = v_rep + REP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_rep        <= '0;
      v_rep        <= '0;
      pixel_index  <= '0;
      line_base    <= '0;
      activeBuffer <= 1'b0;
      fbAddress    <= '0;
      hSync        <= ~SYNC_ACTIVE;
      vSync        <= ~SYNC_ACTIVE;
      dataEnable   <= 1'b0;
      frameStart   <= 1'b0;
    end else begin
      h_rep        <= h_rep_n;
      v_rep        <= v_rep_n;
      pixel_index  <= pixel_index_n;
      line_base    <= line_base_n;
      activeBuffer <= buffer_n;
      // fbAddress is registered one position ahead so the framebuffer sees
      // the address of the current position; it holds during blanking.
      if (visible_next) begin
        fbAddress <= line_base_n + ADDR_WIDTH'(pixel_index_n);
      end
      // Alignment stage: matches the one-cycle read latency of fbData.
      hSync      <= h_sync_raw;
      vSync      <= v_sync_raw;
      dataEnable <= visible;
      frameStart <= frame_start;
    end
  end

  assign pixelOut = dataEnable ? fbData : '0;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_scanout
// Two instances on a small raster (12 x 7 clocks): instance A uses SCALE=2 with
// a 4x2 image, instance B uses SCALE=1 with an 8x4 image. Each has a one-cycle
// RAM model returning data = address. Expected values come from raster
// position arithmetic on a count of output cycles since reset release.
// -----------------------------------------------------------------------------
module tb_framebuffer_scanout;

  localparam int HA = 8, HF = 1, HS = 2, HB = 1;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 12
  localparam int VT = VA + VF + VS + VB;  // 7
  localparam int FT = HT * VT;            // 84
  localparam int PW = 9;
  localparam int AW = 18;
  localparam int A_FBW = 4, A_FBH = 2, A_SC = 2;
  localparam int B_FBW = 8, B_FBH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [AW-1:0] a_addr, b_addr;
  logic [PW-1:0] a_data, b_data, a_pix, b_pix;
  logic a_sel = 1'b0, b_sel = 1'b0;
  logic a_act, a_hs, a_vs, a_de, a_fs;
  logic b_act, b_hs, b_vs, b_de, b_fs;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state for instance A
  int            k_a;     // output cycles since reset release
  bit            buf_a;   // buffer of the frame now on the outputs
  bit            next_a;  // buffer captured at the last frame end
  logic [AW-1:0] hold_a;  // expected fbAddress

  always #5 clk = ~clk;

  // One-cycle registered RAM models, data = address
  always @(posedge clk) begin
    a_data <= a_addr[PW-1:0];
    b_data <= b_addr[PW-1:0];
  end

  framebuffer_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE(A_SC), .FB_W(A_FBW), .FB_H(A_FBH),
    .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .SYNC_ACTIVE(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .fbAddress(a_addr), .fbData(a_data),
    .bufferSelect(a_sel), .activeBuffer(a_act), .hSync(a_hs), .vSync(a_vs),
    .dataEnable(a_de), .pixelOut(a_pix), .frameStart(a_fs)
  );

  framebuffer_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE(1), .FB_W(B_FBW), .FB_H(B_FBH),
    .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .SYNC_ACTIVE(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .fbAddress(b_addr), .fbData(b_data),
    .bufferSelect(b_sel), .activeBuffer(b_act), .hSync(b_hs), .vSync(b_vs),
    .dataEnable(b_de), .pixelOut(b_pix), .frameStart(b_fs)
  );

  task automatic reset_model_a();
    k_a    = 0;
    buf_a  = 1'b0;
    next_a = 1'b0;
    hold_a = '0;
  endtask

  // Runs instance A for n clocks; with sel_rate > 0, bufferSelect toggles at
  // random with probability 1/sel_rate per clock.
  task automatic scan_a(input int n, input int sel_rate);
    int p, h, v, q, qh, qv;
    bit de_e, hs_e, vs_e, fs_e, ab_e, sel_edge;
    logic [PW-1:0] pix_e;
    for (int i = 0; i < n; i++) begin
      if (sel_rate > 0 && $urandom_range(1, sel_rate) == 1) a_sel = ~a_sel;
      sel_edge = a_sel;
      @(posedge clk);
      #1;
      p = k_a % FT;
      h = p % HT;
      v = p / HT;
      if (p == 0 && k_a > 0) buf_a = next_a;
      if (p == FT - 1) next_a = sel_edge;
      ab_e  = (p == FT - 1) ? next_a : buf_a;
      de_e  = (h < HA) && (v < VA);
      pix_e = de_e ? PW'(buf_a * A_FBW * A_FBH + (v / A_SC) * A_FBW + h / A_SC) : '0;
      hs_e  = !(h >= HA + HF && h < HA + HF + HS);
      vs_e  = !(v >= VA + VF && v < VA + VF + VS);
      fs_e  = (p == 0);
      q  = (p + 1) % FT;
      qh = q % HT;
      qv = q / HT;
      if (qh < HA && qv < VA)
        hold_a = AW'(ab_e * A_FBW * A_FBH + (qv / A_SC) * A_FBW + qh / A_SC);

      n_checks++;
      if (a_de !== de_e) begin
        n_fail++;
        $display("FAIL a_dataEnable k=%0d (h=%0d v=%0d) got %b exp %b", k_a, h, v, a_de, de_e);
      end
      n_checks++;
      if (a_pix !== pix_e) begin
        n_fail++;
        $display("FAIL a_pixelOut k=%0d (h=%0d v=%0d) got %0d exp %0d", k_a, h, v, a_pix, pix_e);
      end
      n_checks++;
      if (a_hs !== hs_e) begin
        n_fail++;
        $display("FAIL a_hSync k=%0d (h=%0d v=%0d) got %b exp %b", k_a, h, v, a_hs, hs_e);
      end
      n_checks++;
      if (a_vs !== vs_e) begin
        n_fail++;
        $display("FAIL a_vSync k=%0d (h=%0d v=%0d) got %b exp %b", k_a, h, v, a_vs, vs_e);
      end
      n_checks++;
      if (a_fs !== fs_e) begin
        n_fail++;
        $display("FAIL a_frameStart k=%0d (h=%0d v=%0d) got %b exp %b", k_a, h, v, a_fs, fs_e);
      end
      n_checks++;
      if (a_act !== ab_e) begin
        n_fail++;
        $display("FAIL a_activeBuffer k=%0d (h=%0d v=%0d) got %b exp %b", k_a, h, v, a_act, ab_e);
      end
      n_checks++;
      if (a_addr !== hold_a) begin
        n_fail++;
        $display("FAIL a_fbAddress k=%0d (h=%0d v=%0d) got %0d exp %0d", k_a, h, v, a_addr, hold_a);
      end
      k_a++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({a_de, a_fs, a_hs, a_vs, a_act} !== 5'b00110) begin
        n_fail++;
        $display("FAIL reset_a_ctrl got %b exp 00110", {a_de, a_fs, a_hs, a_vs, a_act});
      end
      n_checks++;
      if ({b_de, b_fs, b_hs, b_vs, b_act} !== 5'b00110) begin
        n_fail++;
        $display("FAIL reset_b_ctrl got %b exp 00110", {b_de, b_fs, b_hs, b_vs, b_act});
      end
      n_checks++;
      if (a_pix !== '0 || b_pix !== '0) begin
        n_fail++;
        $display("FAIL reset_pixelOut got a=%0d b=%0d exp 0", a_pix, b_pix);
      end
      n_checks++;
      if (a_addr !== '0 || b_addr !== '0) begin
        n_fail++;
        $display("FAIL reset_fbAddress got a=%0d b=%0d exp 0", a_addr, b_addr);
      end
    end
  endtask

  // Two frames from reset: line pattern 0,0,1,1,2,2,3,3 twice then 4..7 doubled.
  task automatic test_raster();
    a_sel = 1'b0;
    reset = 1'b0;
    reset_model_a();
    scan_a(2 * FT, 0);
  endtask

  task automatic test_buffer_switch();
    scan_a(30, 0);      // into line 2 of the frame
    a_sel = 1'b1;       // request buffer 1 mid-frame
    scan_a(2 * FT - 30, 0);
    scan_a(4 * FT, 7);  // random requests at arbitrary points
  endtask

  task automatic test_reset_mid_line();
    int guard = 0;
    // Stop when the counters sit at hCount=5, vCount=2.
    while ((k_a % FT) != 2 * HT + 5 && guard < 2 * FT) begin
      scan_a(1, 0);
      guard++;
    end
    n_checks++;
    if ((k_a % FT) != 2 * HT + 5) begin
      n_fail++;
      $display("FAIL mid_line_position got %0d exp %0d", k_a % FT, 2 * HT + 5);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({a_de, a_fs, a_hs, a_vs, a_act} !== 5'b00110) begin
      n_fail++;
      $display("FAIL midreset_ctrl got %b exp 00110", {a_de, a_fs, a_hs, a_vs, a_act});
    end
    n_checks++;
    if (a_pix !== '0 || a_addr !== '0) begin
      n_fail++;
      $display("FAIL midreset_data got pix=%0d addr=%0d exp 0/0", a_pix, a_addr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model_a();
    scan_a(FT + HT, 5);
  endtask

  task automatic test_scale1();
    int p, h, v, idx, n_fs;
    bit de_e;
    logic [PW-1:0] pix_e;
    b_sel = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idx  = 0;
    n_fs = 0;
    for (int k = 0; k < 2 * FT; k++) begin
      @(posedge clk);
      #1;
      p = k % FT;
      h = p % HT;
      v = p / HT;
      de_e  = (h < HA) && (v < VA);
      pix_e = de_e ? PW'(idx) : '0;
      if (de_e) idx = (idx + 1) % (B_FBW * B_FBH);
      if (b_fs === 1'b1) n_fs++;
      n_checks++;
      if (b_de !== de_e) begin
        n_fail++;
        $display("FAIL b_dataEnable k=%0d got %b exp %b", k, b_de, de_e);
      end
      n_checks++;
      if (b_pix !== pix_e) begin
        n_fail++;
        $display("FAIL b_pixelOut k=%0d got %0d exp %0d", k, b_pix, pix_e);
      end
      n_checks++;
      if (b_fs !== (p == 0)) begin
        n_fail++;
        $display("FAIL b_frameStart k=%0d got %b exp %b", k, b_fs, p == 0);
      end
    end
    n_checks++;
    if (n_fs != 2) begin
      n_fail++;
      $display("FAIL b_frameStart_count got %0d exp 2", n_fs);
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_buffer_switch();
    test_reset_mid_line();
    test_scale1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
